// File: rtl/fast_pkg.sv
// Shared types and constants for the FAST corner engine: FSM states, the
// radius-3 Bresenham circle offset table and the circular run-length helper.
package fast_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GAUS,
    ST_FETCH,
    ST_CAPTURE,
    ST_EVAL,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam int NUM_CIRCLE = 16;
  localparam int RADIUS     = 3;
  localparam int FETCH_LAST = NUM_CIRCLE;  // read index of the last circle pixel
  localparam int FIDX_W     = 5;
  localparam int ARC_W      = 5;
  localparam int SCORE_MARGIN = 4;         // score needs PIXEL_W + 4 bits for 16 terms

  typedef logic signed [2:0] off_t;

  localparam off_t CIRC_DX [NUM_CIRCLE] = '{
    3'sd0, 3'sd1, 3'sd2, 3'sd3, 3'sd3, 3'sd3, 3'sd2, 3'sd1,
    3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
  };
  localparam off_t CIRC_DY [NUM_CIRCLE] = '{
    -3'sd3, -3'sd3, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2, 3'sd3,
    3'sd3, 3'sd3, 3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2, -3'sd3
  };

  // Longest run of ones around the circle; walking the mask twice catches
  // runs that wrap from index 15 back to 0.
  function automatic logic [ARC_W-1:0] longest_run(input logic [NUM_CIRCLE-1:0] m);
    logic [ARC_W-1:0] run;
    logic [ARC_W-1:0] best;
    run  = '0;
    best = '0;
    if (&m) begin
      best = ARC_W'(NUM_CIRCLE);
    end else begin
      for (int i = 0; i < 2 * NUM_CIRCLE; i++) begin
        if (m[i[3:0]]) begin
          run = run + 5'd1;
          if (run > best) best = run;
        end else begin
          run = '0;
        end
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/fast_arc_eval.sv
// Combinational segment test: classifies the 16 circle pixels against the
// centre and returns the thresholded score, or 0 when no arc is long enough.
module fast_arc_eval
  import fast_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int SCORE_W = 12
) (
  input  logic [PIXEL_W-1:0]                 c,
  input  logic [NUM_CIRCLE-1:0][PIXEL_W-1:0] p,
  input  logic [PIXEL_W-1:0]                 t,
  input  logic [ARC_W-1:0]                   arc_min,
  output logic [SCORE_W-1:0]                 score
);

  localparam int EW = PIXEL_W + 1;

  logic [NUM_CIRCLE-1:0]              bright;
  logic [NUM_CIRCLE-1:0]              dark;
  logic [NUM_CIRCLE-1:0][SCORE_W-1:0] excess;
  logic [SCORE_W-1:0]                 sum;
  logic [ARC_W-1:0]                   arc_eff;
  logic [ARC_W-1:0]                   bright_run;
  logic [ARC_W-1:0]                   dark_run;
  logic                               corner;

  logic [EW-1:0] ce;
  logic [EW-1:0] te;
  assign ce = EW'(c);
  assign te = EW'(t);

  for (genvar gi = 0; gi < NUM_CIRCLE; gi++) begin : g_pix
    logic [EW-1:0] pe;
    logic [EW-1:0] diff;
    assign pe         = EW'(p[gi]);
    assign bright[gi] = pe > (ce + te);
    assign dark[gi]   = (pe + te) < ce;
    assign diff       = (pe >= ce) ? (pe - ce) : (ce - pe);
    assign excess[gi] = (diff > te) ? SCORE_W'(diff - te) : '0;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CIRCLE; i++) begin
      sum = sum + excess[i];
    end
  end

  assign bright_run = longest_run(bright);
  assign dark_run   = longest_run(dark);
  assign arc_eff    = (arc_min == '0) ? ARC_W'(1) : arc_min;
  assign corner     = (bright_run >= arc_eff) || (dark_run >= arc_eff);
  assign score      = corner ? sum : '0;

endmodule

// File: rtl/fast_corner_engine.sv
// Raster-scan FAST corner engine: paces pixels on Gaussian progress, fetches
// centre + 16-pixel circle, scores it and writes one result per pixel.
module fast_corner_engine
  import fast_pkg::*;
#(
  parameter int X_MAX   = 10,
  parameter int Y_MAX   = 10,
  parameter int PIXEL_W = 8,
  parameter int SCORE_W = 12,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_trans,
  input  logic [$clog2(X_MAX):0] max_x,
  input  logic [$clog2(Y_MAX):0] max_y,
  input  logic [PIXEL_W-1:0]     threshold,
  input  logic [ARC_W-1:0]       arc_min,
  input  logic                   gaus_sample_flag,
  input  logic                   gaus_done,
  output logic                   read_SRAM2,
  output logic [$clog2(X_MAX):0] x_addr,
  output logic [$clog2(Y_MAX):0] y_addr,
  input  logic [PIXEL_W-1:0]     SRAM_in,
  output logic                   write_SRAM4,
  output logic [$clog2(X_MAX):0] x_addr4,
  output logic [$clog2(Y_MAX):0] y_addr4,
  output logic [SCORE_W-1:0]     corner_score,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       corner_count
);

  localparam int XW     = $clog2(X_MAX) + 1;
  localparam int YW     = $clog2(Y_MAX) + 1;
  localparam int SAMP_W = $clog2(X_MAX * Y_MAX + 1);
  localparam int PROD_W = XW + YW + 1;
  localparam logic [XW-1:0] X_LIM = XW'(X_MAX);
  localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX);

  state_t                             state_q, state_d;
  logic [XW-1:0]                      x_q, x_d, mx_q, mx_d;
  logic [YW-1:0]                      y_q, y_d, my_q, my_d;
  logic [PIXEL_W-1:0]                 thr_q, thr_d;
  logic [ARC_W-1:0]                   arc_q, arc_d;
  logic [SAMP_W-1:0]                  samp_q, samp_d;
  logic [FIDX_W-1:0]                  fidx_q, fidx_d;
  logic [PIXEL_W-1:0]                 c_q, c_d;
  logic [NUM_CIRCLE-1:0][PIXEL_W-1:0] pix_q, pix_d;
  logic                               rd_q, rd_d, wr_q, wr_d;
  logic [XW-1:0]                      xa_q, xa_d, xa4_q, xa4_d;
  logic [YW-1:0]                      ya_q, ya_d, ya4_q, ya4_d;
  logic [SCORE_W-1:0]                 score_q, score_d;
  logic                               busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;

  logic [SCORE_W-1:0] eval_score;
  logic [YW:0]        rows_need;
  logic [PROD_W-1:0]  need, limit;
  logic               gate_ok;
  logic               row_end, last_px;
  logic [XW-1:0]      nx;
  logic [YW-1:0]      ny;
  logic [3:0]         circ_idx;
  off_t               dx, dy;

  function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                     input logic [XW-1:0] mx, input logic [YW-1:0] my);
    return (x < XW'(RADIUS)) || (y < YW'(RADIUS)) ||
           (({1'b0, x} + (XW+1)'(RADIUS)) >= {1'b0, mx}) ||
           (({1'b0, y} + (YW+1)'(RADIUS)) >= {1'b0, my});
  endfunction

  fast_arc_eval #(
    .PIXEL_W (PIXEL_W),
    .SCORE_W (SCORE_W)
  ) u_arc_eval (
    .c       (c_q),
    .p       (pix_q),
    .t       (thr_q),
    .arc_min (arc_q),
    .score   (eval_score)
  );

  // A pixel may start once the rows down to y+3 have been filtered.
  assign rows_need = (({1'b0, y_q} + (YW+1)'(RADIUS + 1)) < {1'b0, my_q}) ?
                     ({1'b0, y_q} + (YW+1)'(RADIUS + 1)) : {1'b0, my_q};
  assign need      = PROD_W'(rows_need) * PROD_W'(mx_q);
  assign limit     = PROD_W'(my_q) * PROD_W'(mx_q);
  assign gate_ok   = gaus_done || (PROD_W'(samp_q) >= need);

  assign row_end = (x_q == mx_q - 1'b1);
  assign last_px = row_end && (y_q == my_q - 1'b1);
  assign nx      = row_end ? '0 : x_q + 1'b1;
  assign ny      = row_end ? y_q + 1'b1 : y_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mx_d     = mx_q;
    my_d     = my_q;
    thr_d    = thr_q;
    arc_d    = arc_q;
    samp_d   = samp_q;
    fidx_d   = fidx_q;
    c_d      = c_q;
    pix_d    = pix_q;
    cnt_d    = cnt_q;
    score_d  = '0;
    circ_idx = '0;
    dx       = '0;
    dy       = '0;

    if (state_q == ST_IDLE) begin
      if (new_trans) begin
        // Zero size is lifted to 1 so the scan always reaches a last pixel.
        mx_d    = (max_x > X_LIM) ? X_LIM : ((max_x == '0) ? XW'(1) : max_x);
        my_d    = (max_y > Y_LIM) ? Y_LIM : ((max_y == '0) ? YW'(1) : max_y);
        thr_d   = threshold;
        arc_d   = arc_min;
        samp_d  = gaus_sample_flag ? SAMP_W'(1) : '0;
        cnt_d   = '0;
        x_d     = '0;
        y_d     = '0;
        state_d = ST_WAIT_GAUS;
      end
    end else if (gaus_sample_flag && (PROD_W'(samp_q) < limit)) begin
      samp_d = samp_q + 1'b1;
    end

    case (state_q)
      ST_WAIT_GAUS: begin
        if (is_border(x_q, y_q, mx_q, my_q)) begin
          state_d = ST_WRITE;
        end else if (gate_ok) begin
          fidx_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // SRAM_in carries the datum requested one cycle earlier.
        if (fidx_q == FIDX_W'(1)) begin
          c_d = SRAM_in;
        end else if (fidx_q >= FIDX_W'(2)) begin
          pix_d[fidx_q[3:0] - 4'd2] = SRAM_in;
        end
        if (fidx_q == FIDX_W'(FETCH_LAST)) begin
          state_d = ST_CAPTURE;
        end else begin
          fidx_d = fidx_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        pix_d[NUM_CIRCLE-1] = SRAM_in;
        state_d             = ST_EVAL;
      end
      ST_EVAL: begin
        score_d = eval_score;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if ((score_q != '0) && !(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (last_px) begin
          state_d = ST_DONE;
        end else begin
          x_d     = nx;
          y_d     = ny;
          state_d = is_border(nx, ny, mx_q, my_q) ? ST_WRITE : ST_WAIT_GAUS;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    rd_d   = (state_d == ST_FETCH);
    wr_d   = (state_d == ST_WRITE);
    xa_d   = '0;
    ya_d   = '0;
    xa4_d  = '0;
    ya4_d  = '0;
    if (rd_d) begin
      if (fidx_d == '0) begin
        xa_d = x_d;
        ya_d = y_d;
      end else begin
        circ_idx = fidx_d[3:0] - 4'd1;
        dx       = CIRC_DX[circ_idx];
        dy       = CIRC_DY[circ_idx];
        xa_d     = x_d + {{(XW-3){dx[2]}}, dx};
        ya_d     = y_d + {{(YW-3){dy[2]}}, dy};
      end
    end
    if (wr_d) begin
      xa4_d = x_d;
      ya4_d = y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      thr_q   <= '0;
      arc_q   <= '0;
      samp_q  <= '0;
      fidx_q  <= '0;
      c_q     <= '0;
      pix_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      xa_q    <= '0;
      ya_q    <= '0;
      xa4_q   <= '0;
      ya4_q   <= '0;
      score_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      thr_q   <= thr_d;
      arc_q   <= arc_d;
      samp_q  <= samp_d;
      fidx_q  <= fidx_d;
      c_q     <= c_d;
      pix_q   <= pix_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      xa4_q   <= xa4_d;
      ya4_q   <= ya4_d;
      score_q <= score_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign read_SRAM2   = rd_q;
  assign x_addr       = xa_q;
  assign y_addr       = ya_q;
  assign write_SRAM4  = wr_q;
  assign x_addr4      = xa4_q;
  assign y_addr4      = ya4_q;
  assign corner_score = score_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign corner_count = cnt_q;

endmodule
